// File: rtl/arbitro_pkg.sv
// Shared constants and helpers for the arbitro_rr FIFO arbiter.
// Stats counter widths apply only when ARB_STATS_EN is defined.
package arbitro_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam int PUSH_CNT_W = 16;
    localparam int DROP_CNT_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width for an n-entry vector; never zero so the vector stays declarable.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/arbitro_rr_grant.sv
// rr_grant: combinational N-request picker, round-robin from ptr or fixed lowest-first.
module rr_grant #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] nxt_ptr
);
    int   base;
    int   idx;
    logic found;

    always_comb begin
        grant   = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = 0;
        base    = mode ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt_ptr    = PTR_W'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr: pops N_IN input FIFOs (RR or fixed priority) and routes each word to an output FIFO.
// Define ARB_STATS_EN to add the push_count / drop_count statistics ports.
module arbitro_rr
    import arbitro_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 4,
    parameter int DATA_W  = 10,
    parameter int RR_MODE = MODE_RR
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_IN-1:0]             empty,
    input  logic [N_IN*DATA_W-1:0]      data_in,
    input  logic [N_OUT-1:0]            almost_full,
    output logic [N_IN-1:0]             pop,
    output logic [N_OUT-1:0]            push,
    output logic [DATA_W-1:0]           data_out,
    output logic                        dest_err,
    output logic                        idle
`ifdef ARB_STATS_EN
    ,
    output logic [N_OUT*PUSH_CNT_W-1:0] push_count,
    output logic [DROP_CNT_W-1:0]       drop_count
`endif
);
    localparam int   DEST_W = idx_w(N_OUT);
    localparam int   PTR_W  = idx_w(N_IN);
    localparam logic RR_SEL = (RR_MODE == MODE_RR);

    logic [N_IN-1:0][DATA_W-1:0] din;
    logic [PTR_W-1:0]            ptr, ptr_nxt;
    logic [N_IN-1:0]             cand, gnt, pop_nxt;
    logic                        stall, in_flight;
    logic [DATA_W-1:0]           cap_word;
    logic [DEST_W-1:0]           cap_dest;
    logic                        cap_ok, drop_nxt;
    logic [N_OUT-1:0]            push_nxt;

    assign din   = data_in;
    assign stall = |almost_full;
    // The current pop vector masks the not-yet-updated empty flag of the FIFO being read.
    assign cand  = ~empty & ~pop;

    rr_grant #(
        .N     (N_IN),
        .PTR_W (PTR_W)
    ) u_grant (
        .req     (cand),
        .ptr     (ptr),
        .mode    (RR_SEL),
        .grant   (gnt),
        .nxt_ptr (ptr_nxt)
    );

    assign pop_nxt  = stall ? '0 : gnt;
    assign cap_dest = cap_word[DATA_W-1 -: DEST_W];
    assign cap_ok   = int'(cap_dest) < N_OUT;

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < N_IN; i++)
            if (pop[i]) cap_word = din[i];
    end

    always_comb begin
        push_nxt = '0;
        drop_nxt = 1'b0;
        if (in_flight) begin
            if (cap_ok) begin
                for (int o = 0; o < N_OUT; o++)
                    if (int'(cap_dest) == o) push_nxt[o] = 1'b1;
            end else begin
                drop_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop       <= '0;
            push      <= '0;
            data_out  <= '0;
            dest_err  <= 1'b0;
            idle      <= 1'b1;
            ptr       <= '0;
            in_flight <= 1'b0;
        end else begin
            pop       <= pop_nxt;
            in_flight <= |pop_nxt;
            if (|pop_nxt) ptr <= ptr_nxt;
            push      <= push_nxt;
            dest_err  <= drop_nxt;
            if (|push_nxt) data_out <= cap_word;
            idle      <= ~(|pop_nxt) & ~(|push_nxt);
        end
    end

`ifdef ARB_STATS_EN
    logic [N_OUT-1:0][PUSH_CNT_W-1:0] pcnt;
    logic [DROP_CNT_W-1:0]            dcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            dcnt <= '0;
        end else begin
            for (int o = 0; o < N_OUT; o++)
                if (push_nxt[o]) pcnt[o] <= pcnt[o] + 1'b1;
            if (drop_nxt && dcnt != '1) dcnt <= dcnt + 1'b1;
        end
    end

    assign push_count = pcnt;
    assign drop_count = dcnt;
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: a round-robin instance checked against FIFO-queue scoreboard,
// plus a fixed-priority N_OUT=3 instance for routing / illegal-destination drops.
module tb_arbitro_rr;
    localparam int NI = 4;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NI-1:0]    empty, almost_full, pop, push;
    logic [NI*DW-1:0] data_in;
    logic [DW-1:0]    data_out;
    logic             dest_err, idle;

    logic [NI-1:0]    empty_f, af_f, pop_f;
    logic [NI*DW-1:0] din_f;
    logic [2:0]       push_f;
    logic [DW-1:0]    dout_f;
    logic             err_f, idle_f;

`ifdef ARB_STATS_EN
    logic [4*16-1:0] pcnt;
    logic [7:0]      dcnt;
    logic [3*16-1:0] pcnt_f;
    logic [7:0]      dcnt_f;
`endif

    arbitro_rr #(.N_IN(4), .N_OUT(4), .DATA_W(DW), .RR_MODE(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .data_in     (data_in),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .dest_err    (dest_err),
        .idle        (idle)
`ifdef ARB_STATS_EN
        ,
        .push_count  (pcnt),
        .drop_count  (dcnt)
`endif
    );

    arbitro_rr #(.N_IN(4), .N_OUT(3), .DATA_W(DW), .RR_MODE(0)) u_fix (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty_f),
        .data_in     (din_f),
        .almost_full (af_f),
        .pop         (pop_f),
        .push        (push_f),
        .data_out    (dout_f),
        .dest_err    (err_f),
        .idle        (idle_f)
`ifdef ARB_STATS_EN
        ,
        .push_count  (pcnt_f),
        .drop_count  (dcnt_f)
`endif
    );

    typedef struct {
        logic [3:0]    push;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo[NI][$];
    logic [NI-1:0] pop_seen;
    int            n_pop[NI];
    int            push_out[NI];
    int            n_push;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            empty[i] = (fifo[i].size() == 0);
            data_in[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    function automatic int qtot();
        int s;
        s = 0;
        for (int i = 0; i < NI; i++) s += fifo[i].size();
        return s;
    endfunction

    task automatic clr_counts();
        n_push = 0;
        for (int i = 0; i < NI; i++) begin
            n_pop[i]    = 0;
            push_out[i] = 0;
        end
    endtask

    // Mid-cycle: compare the push due from last cycle's pop, then log this cycle's pop.
    task automatic sample();
        exp_t e;
        int   idx;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("push", push, e.push);
            chk("data_out", data_out, e.data);
        end else begin
            chk("push_none", push, 0);
        end
        chk("dest_err", dest_err, 0);
        if (|push) n_push++;
        for (int o = 0; o < NI; o++) if (push[o]) push_out[o]++;
        if (pop != 0) begin
            chk("pop_1hot", $onehot(pop), 1);
            idx = 0;
            for (int i = 0; i < NI; i++) if (pop[i]) idx = i;
            n_pop[idx]++;
            if (fifo[idx].size() == 0) begin
                chk("pop_nonempty", 0, 1);
            end else begin
                e.data = fifo[idx][0];
                e.push = 4'b0001 << e.data[DW-1 -: 2];
                sb.push_back(e);
            end
            pop_seen = pop;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            if (pop_seen[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        pop_seen = '0;
        drive();
        @(negedge clk);
        sample();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, tot;
        bit found;
        reset       = 1'b1;
        almost_full = '0;
        pop_seen    = '0;
        empty_f     = '1;
        af_f        = '0;
        din_f       = '0;
        din_f[9:0]   = 10'h2A5;
        din_f[29:20] = 10'h3C3;
        drive();
        clr_counts();

        repeat (2) @(negedge clk);
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_err", dest_err, 0);
        chk("rst_idle", idle, 1);
        chk("rst_pop_f", pop_f, 0);
        reset = 1'b0;

        // reset while a word is in flight
        repeat (3) step();
        fifo[2].push_back(10'h155);
        drive();
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            step();
            if (pop[2]) found = 1;
        end
        chk("mid_pop2_seen", found, 1);
        reset    = 1'b1;
        sb.delete();
        pop_seen = '0;
        clr_counts();
        for (int t = 0; t < 3; t++) begin
            step();
            chk("mid_idle", idle, 1);
            chk("mid_pop", pop, 0);
        end
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 110; k++) fifo[i].push_back(10'($urandom_range(0, 1023)));
        drive();
        reset = 1'b0;

        // fairness: pointer restarts at 0, then 0,1,2,3 forever
        for (int n = 0; n < 400; n++) begin
            step();
            chk("rr_pop", pop, 4'b0001 << (n % 4));
        end
        for (int i = 0; i < NI; i++) chk("rr_share", n_pop[i], 100);

        // back-pressure
        almost_full = 4'b1000;
        base = n_push;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("bp_pop", pop, 0);
        end
        chk("bp_push_max", ((n_push - base) <= 2), 1);
        almost_full = '0;
        step();
        chk("bp_resume", |pop, 1);

        for (int t = 0; t < 200 && (qtot() != 0 || !idle || sb.size() != 0); t++) step();
        chk("drain_idle", idle, 1);
        chk("drain_empty", qtot(), 0);

        // one-word FIFO: stale empty must not cause a second pop
        for (int i = 0; i < NI; i++) n_pop[i] = 0;
        base = n_push;
        fifo[1].push_back(10'h0C7);
        drive();
        repeat (8) step();
        tot = n_pop[0] + n_pop[1] + n_pop[2] + n_pop[3];
        chk("one_pop1", n_pop[1], 1);
        chk("one_pop_tot", tot, 1);
        chk("one_push", n_push - base, 1);
        chk("one_idle", idle, 1);

        // fixed priority, inputs 0 (dest 2) and 2 (dest 3, illegal)
        empty_f = 4'b1010;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("fx_pop", pop_f, (n % 2 == 0) ? 1 : 4);
            chk("fx_idle_busy", idle_f, 0);
            if (n > 0) begin
                chk("fx_push", push_f, (n % 2 == 1) ? 3'b100 : 3'b000);
                chk("fx_err", err_f, (n % 2 == 0) ? 1 : 0);
                chk("fx_dout", dout_f, 10'h2A5);
            end
        end
        empty_f = '1;
        step();
        chk("fx_err_last", err_f, 1);
        repeat (2) step();
        chk("fx_idle", idle_f, 1);
        chk("fx_err_end", err_f, 0);
        chk("fx_push_end", push_f, 0);

`ifdef ARB_STATS_EN
        chk("st_drop_f", dcnt_f, 4);
        chk("st_push_f2", pcnt_f[2*16 +: 16], 4);
        chk("st_push_f0", pcnt_f[0 +: 16], 0);
        chk("st_drop", dcnt, 0);
        for (int o = 0; o < NI; o++) chk("st_push", pcnt[o*16 +: 16], push_out[o]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
